// File: rtl/alu_pkg.sv
// Shared ALU constants and signed-limit helpers.
// The limit helpers return a SAT_MAX_W-bit vector; callers keep the low WIDTH bits.
package alu_pkg;

   localparam int ALU_WIDTH     = 32;
   localparam int ADDSUB_STAGES = 4;
   localparam int SAT_MAX_W     = 256;

   // Largest positive two's-complement value of width w: 0111...1
   function automatic logic [SAT_MAX_W-1:0] SAT_POS(input int w);
      return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
   endfunction

   // Most negative two's-complement value of width w: 1000...0
   function automatic logic [SAT_MAX_W-1:0] SAT_NEG(input int w);
      return SAT_MAX_W'(1) << (w - 1);
   endfunction

endpackage

// File: rtl/adder_chunk.sv
// One CHUNK-bit slice of the carry chain. Purely combinational.
// c_msb is the carry into the top bit, needed by the last slice for signed overflow.
module adder_chunk
   import alu_pkg::*;
#(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

   // Carry into the top bit recovered from the top bit's sum equation.
   assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit add/subtract, one CHUNK-bit slice per stage, with
// valid/ready on both sides and a single global stall.
// Optional macro PIPE_ADDSUB_SAT_EN: clamp the result to the signed limit on overflow.
module pipe_addsub
   import alu_pkg::*;
#(
   parameter int WIDTH  = ALU_WIDTH,
   parameter int STAGES = ADDSUB_STAGES
) (
   input  logic             clock,
   input  logic             clear_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int CHUNK = WIDTH / STAGES;

   if (WIDTH % STAGES != 0) begin : g_bad_cfg
      $fatal(1, "pipe_addsub: STAGES must divide WIDTH exactly");
   end

   logic                         advance;
   logic [STAGES-1:0]            vld_q, cy_q;
   logic [STAGES-1:0][WIDTH-1:0] res_q, a_q, b_q;
   logic [STAGES-1:0]            v_in, c_in, co, cm;
   logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, r_in, r_nxt;
   logic [STAGES-1:0][CHUNK-1:0] sum;
   logic [WIDTH-1:0]             raw, res_fin;
   logic                         ovf_nxt, zero_nxt, ovf_q, zero_q;

   // Whole pipe moves together; a held output freezes every stage.
   assign advance  = !vld_q[STAGES-1] || out_ready;
   assign in_ready = advance;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign v_in[s] = in_valid;
         assign a_in[s] = a;
         assign b_in[s] = sub ? ~b : b;
         assign c_in[s] = sub | cin;
         assign r_in[s] = '0;
      end else begin : g_body
         assign v_in[s] = vld_q[s-1];
         assign a_in[s] = a_q[s-1];
         assign b_in[s] = b_q[s-1];
         assign c_in[s] = cy_q[s-1];
         assign r_in[s] = res_q[s-1];
      end

      adder_chunk #(.CHUNK(CHUNK)) u_chunk (
         .a     (a_in[s][s*CHUNK +: CHUNK]),
         .b     (b_in[s][s*CHUNK +: CHUNK]),
         .cin   (c_in[s]),
         .sum   (sum[s]),
         .cout  (co[s]),
         .c_msb (cm[s])
      );

      // Bits above the finished chunks are always zero, so OR-in places the new slice.
      assign r_nxt[s] = r_in[s] | (WIDTH'(sum[s]) << (s * CHUNK));
   end

   assign raw     = r_nxt[STAGES-1];
   assign ovf_nxt = co[STAGES-1] ^ cm[STAGES-1];

`ifdef PIPE_ADDSUB_SAT_EN
   localparam logic [SAT_MAX_W-1:0] POS_FULL = SAT_POS(WIDTH);
   localparam logic [SAT_MAX_W-1:0] NEG_FULL = SAT_NEG(WIDTH);
   // A wrapped-negative raw result means the true value overflowed upward.
   assign res_fin = !ovf_nxt ? raw :
                    (raw[WIDTH-1] ? POS_FULL[WIDTH-1:0] : NEG_FULL[WIDTH-1:0]);
`else
   assign res_fin = raw;
`endif

   assign zero_nxt = (res_fin == '0);

   // Stage registers; the last stage also captures the final result and flags.
   always_ff @(posedge clock) begin
      if (!clear_n) begin
         vld_q  <= '0;
         cy_q   <= '0;
         res_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (advance) begin
         vld_q           <= v_in;
         cy_q            <= co;
         a_q             <= a_in;
         b_q             <= b_in;
         res_q           <= r_nxt;
         res_q[STAGES-1] <= res_fin;
         ovf_q           <= ovf_nxt;
         zero_q          <= zero_nxt;
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign result    = res_q[STAGES-1];
   assign cout      = cy_q[STAGES-1];
   assign ovf       = ovf_q;
   assign zero      = zero_q;

   // Operand skew past the last stage and lower-slice top carries are not consumed.
   logic unused_tail;
   assign unused_tail = ^{a_q[STAGES-1], b_q[STAGES-1], cm};

endmodule

// File: doc/pipe_addsub.md
Name: pipe_addsub

Overview:
- Parametrised, pipelined integer adder/subtractor. Successor to the single-cycle 32-bit ripple adder in the ALU datapath.
- Splits a WIDTH-bit add/sub into STAGES ripple chunks. Each chunk's carry is registered between stages, so the critical path is one chunk.
- Uses a valid/ready handshake on both sides, so the ALU or a multi-cycle MUL/DIV sequencer can issue one operation per clock and stall on backpressure.
- Produces result plus carry, signed-overflow and zero flags.

Parameters:
- WIDTH, 32, operand/result width in bits.
- STAGES, 4, pipeline depth and chunk count. Must divide WIDTH exactly; otherwise elaboration fatal. CHUNK = WIDTH/STAGES.

Ports:
- clock  in  1  single clock, rising edge.
- clear_n  in  1  synchronous, active-low reset, sampled on the rising edge of clock.
- in_valid  in  1  operand beat offered.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  1 = A-B, 0 = A+B+cin.
- cin  in  1  carry-in for add; ignored when sub=1.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum/difference.
- cout  out  1  carry out of the MSB. For sub: 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  result == 0.

Behaviour:
- Transfer rules: input transfer occurs when in_valid && in_ready at a rising edge. Output transfer occurs when out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready. in_ready = advance, combinational from out_valid/out_ready only, not from in_valid.
- Stage register s (0..STAGES-1) holds:
  - a valid bit;
  - low result bits [(s+1)*CHUNK-1:0];
  - the carry out of chunk s;
  - the skewed, not-yet-added upper slices of A and effective B.
- Stage 0 computes chunk 0 with carry-in = sub ? 1 : cin and effective B = sub ? ~b : b. Stage s computes chunk s from stage s-1's registered carry.
- All stage registers load only when advance=1. Bubbles (valid=0) propagate; no bubble collapsing.
- Latency: a beat accepted at edge k is presented with out_valid=1 after edge k+STAGES-1. STAGES=1 gives a registered single-cycle adder.
- Throughput: 1 beat per clock when out_ready is held high.
- Flags, computed in the last stage:
  - cout = carry out of bit WIDTH-1;
  - ovf = carry into MSB XOR carry out of MSB;
  - zero = (result == 0) after saturation, if enabled.
- Outputs hold stable while out_valid && !out_ready.
- Reset (clear_n=0 at an edge): all valid bits cleared; result, cout, ovf and zero cleared to 0. In-flight beats are discarded with no output. in_ready=1 in the first cycle after reset.
- Simultaneous events: output accept and input accept in the same cycle are both honoured, with no loss or duplication.
- An input offered while stalled is not taken; the source must hold it.
- Arithmetic wraps modulo 2^WIDTH. No exception is raised; ovf is informational.

Optional Feature:
- Macro: PIPE_ADDSUB_SAT_EN.
- Defined: when ovf=1, result is clamped to the signed limit in the last stage. Positive overflow gives 0x7FFF...F; negative overflow gives 0x8000...0. ovf is still reported 1; cout is unchanged; zero is computed on the clamped value.
- Undefined: result wraps as above and no clamp logic is synthesised.

Decomposition:
- Package alu_pkg holds:
  - ALU_WIDTH default (32);
  - ADDSUB_STAGES default (4);
  - the signed-limit constants SAT_POS and SAT_NEG as WIDTH-parametric functions.
- Sub-module adder_chunk, parametrised by CHUNK: combinational ripple chunk with inputs a, b, cin and outputs sum, cout, c_msb (carry into top bit, used by the last stage for ovf). pipe_addsub instantiates it STAGES times.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Add, no stall, out_ready=1: a=0x0000_FFFF, b=0x0000_0001, sub=0, cin=0, accepted at edge 0 -> out_valid after edge 3, result=0x0001_0000, cout=0, ovf=0, zero=0.
- Signed overflow: a=0x7FFF_FFFF, b=1, sub=0 -> result=0x8000_0000, ovf=1, cout=0. With PIPE_ADDSUB_SAT_EN: result=0x7FFF_FFFF, ovf=1.
- Subtract to zero, with carry-chain across all chunks: a=b=0x1234_5678, sub=1, cin=1 (ignored) -> result=0, zero=1, cout=1, ovf=0.
- Also: a=0, b=1, sub=1 -> result=0xFFFF_FFFF, cout=0.
- Backpressure, streaming: 8 back-to-back beats (a=i, b=i, i=1..8) with out_ready low for cycles 5-7 -> in_ready low exactly while out_valid && !out_ready; outputs 2,4,...,16 delivered in order, none lost or duplicated; held values stable during the stall.
- Reset mid-operation: 3 beats in flight, clear_n=0 for one edge -> out_valid=0 and all outputs 0 next cycle; none of the 3 results ever appears; a new beat accepted after reset emerges at the normal latency.
- Parameter sweep: STAGES=1 and STAGES=8, plus WIDTH=16/STAGES=2, with 10k random beats and random out_ready -> results match the a+b+cin / a-b reference model bit-exactly including flags. STAGES=3 with WIDTH=32 -> elaboration fatal.
